// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu divider block.
// Optional macro ROUND_EN selects half-LSB rounding of the quotient instead of truncation.
package cpu_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_t;

    localparam int ADDR_N_HI  = 0;
    localparam int ADDR_N_LO  = 1;
    localparam int ADDR_D     = 2;
    localparam int ADDR_Q_HI  = 4;
    localparam int ADDR_Q_MID = 5;
    localparam int ADDR_Q_LO  = 6;
    localparam int DIV_ITERS  = 25;
    localparam int RESULT_W   = 24;

    // q carries one guard bit below the stored result; div_zero forces all-ones.
    function automatic logic [RESULT_W-1:0] finish_q(input logic [DIV_ITERS-1:0] q,
                                                     input logic div_zero);
        logic [RESULT_W:0] sum;
        if (div_zero)
            return {RESULT_W{1'b1}};
`ifdef ROUND_EN
        sum = {1'b0, q[DIV_ITERS-1:1]} + {{RESULT_W{1'b0}}, q[0]};
        return sum[RESULT_W] ? {RESULT_W{1'b1}} : sum[RESULT_W-1:0];
`else
        sum = {1'b0, q[DIV_ITERS-1:1]};
        return sum[RESULT_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/cpu_data_mem.sv
// Byte-wide data memory: combinational read, synchronous write, no reset so contents survive.
module data_mem #(
    parameter int DM_DEPTH = 256,
    parameter int DATA_W   = 8,
    parameter int AW       = $clog2(DM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] Core [0:DM_DEPTH-1];

    assign rdata = Core[addr];

    always_ff @(posedge clk)
        if (we) Core[addr] <= wdata;

endmodule

// File: rtl/cpu.sv
// Memory-mapped divider: Q = floor({Core[0],Core[1]}*256/Core[2]) written to Core[4..6].
// Build option ROUND_EN rounds the quotient (see cpu_pkg); latency is unchanged.
module cpu
    import cpu_pkg::*;
#(
    parameter int DM_DEPTH = 256,
    parameter int DATA_W   = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);

    localparam int AW = $clog2(DM_DEPTH);

    state_t                 state, state_nx;
    logic                   start_q;
    logic [4:0]             cnt;
    logic [15:0]            n;
    logic [7:0]             d, rem, rem_nx;
    logic [DIV_ITERS-1:0]   dvd;
    logic [8:0]             trial;
    logic                   ge;
    logic [RESULT_W-1:0]    q_res;
    logic [AW-1:0]          addr;
    logic                   we;
    logic [DATA_W-1:0]      wdata, rdata;

    data_mem #(.DM_DEPTH(DM_DEPTH), .DATA_W(DATA_W), .AW(AW)) DM1 (
        .clk   (Clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_q && !Start)                 state_nx = LOAD;
            LOAD:    if (cnt == 5'd2)                       state_nx = DIV;
            DIV:     if (cnt == 5'(DIV_ITERS - 1))          state_nx = STORE;
            STORE:   if (cnt == 5'd2)                       state_nx = DONE;
            DONE:    if (Start)                             state_nx = IDLE;
            default:                                        state_nx = IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial  = {rem, dvd[DIV_ITERS-1]};
    assign ge     = trial >= {1'b0, d};
    assign rem_nx = ge ? 8'(trial - {1'b0, d}) : trial[7:0];
    assign q_res  = finish_q(dvd, d == 8'd0);

    always_comb begin
        addr  = '0;
        we    = 1'b0;
        wdata = '0;
        if (state == LOAD)
            addr = AW'(ADDR_N_HI + int'(cnt));
        else if (state == STORE) begin
            addr = AW'(ADDR_Q_HI + int'(cnt));
            we   = 1'b1;
            case (cnt)
                5'd0:    wdata = DATA_W'(q_res[23:16]);
                5'd1:    wdata = DATA_W'(q_res[15:8]);
                default: wdata = DATA_W'(q_res[7:0]);
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            start_q <= 1'b0;
            cnt     <= '0;
            n       <= '0;
            d       <= '0;
            rem     <= '0;
            dvd     <= '0;
            Ack     <= 1'b0;
        end else begin
            start_q <= Start;
            Ack     <= (state == DONE) && (state_nx == DONE);
            if (state_nx != state)
                cnt <= '0;
            else if (state == LOAD || state == DIV || state == STORE)
                cnt <= cnt + 5'd1;
            case (state)
                LOAD: case (cnt)
                    5'd0:    n[15:8] <= rdata[7:0];
                    5'd1:    n[7:0]  <= rdata[7:0];
                    default: begin
                        d   <= rdata[7:0];
                        dvd <= {n, 9'b0};
                        rem <= '0;
                    end
                endcase
                // A zero divisor just idles through the iterations to keep latency fixed.
                DIV: if (d != 8'd0) begin
                    rem <= rem_nx;
                    dvd <= {dvd[DIV_ITERS-2:0], ge};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Randomized self-checking bench for cpu against an arithmetic quotient model.
module tb_cpu;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Start = 1'b1;
    logic Ack;
    int   n_chk = 0;
    int   n_err = 0;

    cpu #(.DM_DEPTH(256), .DATA_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Ack   (Ack)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] model(input int unsigned nv, input int unsigned dv);
        longint unsigned q, r;
        if (dv == 0) return 24'hFFFFFF;
        q = (longint'(nv) * 512) / dv;
`ifdef ROUND_EN
        r = (q >> 1) + (q & 1);
        if (r > 64'hFFFFFF) r = 64'hFFFFFF;
`else
        r = q >> 1;
`endif
        return r[23:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One complete run; abort_at > 0 pulses reset that many edges after launch instead.
    task automatic run(input logic [15:0] nv, input logic [7:0] dv, input bit jitter,
                       input int abort_at);
        logic [7:0]  c3, c7, g4, g5, g6;
        logic [23:0] exp;
        int          cyc;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        c3 = 8'($urandom); c7 = 8'($urandom);
        g4 = 8'($urandom); g5 = 8'($urandom); g6 = 8'($urandom);
        dut.DM1.Core[0] = nv[15:8];
        dut.DM1.Core[1] = nv[7:0];
        dut.DM1.Core[2] = dv;
        dut.DM1.Core[3] = c3;
        dut.DM1.Core[4] = g4;
        dut.DM1.Core[5] = g5;
        dut.DM1.Core[6] = g6;
        dut.DM1.Core[7] = c7;
        Start = 1'b0;
        @(posedge Clk);
        cyc = 0;
        while (cyc < 64) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            if (abort_at == cyc) begin
                Reset = 1'b0;
                #1 chk("rst_ack", Ack, 0);
                repeat (3) @(negedge Clk);
                chk("rst_q_hi", dut.DM1.Core[4], g4);
                chk("rst_q_mid", dut.DM1.Core[5], g5);
                chk("rst_q_lo", dut.DM1.Core[6], g6);
                chk("rst_ack_hold", Ack, 0);
                Reset = 1'b1;
                return;
            end
            if (Ack) break;
            Start = (jitter && cyc < 20) ? 1'($urandom) : 1'b0;
        end
        chk("latency", cyc, 32);
        exp = model(nv, dv);
        chk("q_hi", dut.DM1.Core[4], exp[23:16]);
        chk("q_mid", dut.DM1.Core[5], exp[15:8]);
        chk("q_lo", dut.DM1.Core[6], exp[7:0]);
        chk("core3", dut.DM1.Core[3], c3);
        chk("core7", dut.DM1.Core[7], c7);
        @(negedge Clk);
        chk("ack_hold", Ack, 1);
        Start = 1'b1;
        @(negedge Clk);
        chk("ack_drop", Ack, 0);
    endtask

    initial begin
        #1 chk("reset_ack", Ack, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        run(16'd385,   8'd6,   1'b0, 0);
        run(16'd3,     8'd255, 1'b0, 0);
        run(16'hFFFF,  8'd1,   1'b0, 0);
        run(16'h0000,  8'd7,   1'b0, 0);
        run(16'h1234,  8'd0,   1'b0, 0);
        run(16'd385,   8'd6,   1'b0, 10);
        run(16'd385,   8'd6,   1'b0, 0);
        run(16'd100,   8'd3,   1'b0, 0);
        run(16'd1,     8'd2,   1'b0, 0);
        for (int i = 0; i < 24; i++) begin
            logic [15:0] rn;
            logic [7:0]  rd;
            rn = 16'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run(rn, rd, 1'b1, 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
